// File: rtl/fpu_execute_stage_if.sv
// rtl/fpu_execute_stage_if.sv - ID/EX operand side and EX/WB result side of the FP32 execute stage
interface fpu_execute_stage_if;
    logic [31:0] RLeftIn;
    logic [31:0] RRightIn;
    logic [4:0]  RDAddressIn;
    logic [3:0]  FlagsIn;
    logic [31:0] ResultOut;
    logic [4:0]  RDAddressOut;
    logic        WriteEnOut;
    logic        DoneOut;
    logic        OverflowOut;
    logic        UnderflowOut;
    logic        Stall;

    modport master (
        output RLeftIn, RRightIn, RDAddressIn, FlagsIn,
        input  ResultOut, RDAddressOut, WriteEnOut, DoneOut, OverflowOut, UnderflowOut, Stall
    );

    modport slave (
        input  RLeftIn, RRightIn, RDAddressIn, FlagsIn,
        output ResultOut, RDAddressOut, WriteEnOut, DoneOut, OverflowOut, UnderflowOut, Stall
    );
endinterface

// File: rtl/fpu_execute_stage.sv
// rtl/fpu_execute_stage.sv - FP32 execute stage: single-cycle add/sub/move, 24-step shift-add multiply
module fpu_execute_stage (
    input logic                clk,
    input logic                rst,
    fpu_execute_stage_if.slave bus
);
    typedef enum logic [1:0] {IDLE, MUL, NORM} state_t;

    localparam logic [1:0]  OP_FSUB = 2'b01;
    localparam logic [1:0]  OP_FMUL = 2'b10;
    localparam logic [1:0]  OP_MOVE = 2'b11;
    localparam logic [31:0] QNAN    = 32'h7FC0_0000;

    state_t      state, state_next;
    logic [31:0] result_q;
    logic [4:0]  rd_q, mul_rd;
    logic        we_q, done_q, of_q, uf_q, mul_we;
    logic        mul_sign, mul_special;
    logic [31:0] mul_special_res;
    logic [9:0]  mul_exp;
    logic [23:0] mcand, mplier;
    logic [47:0] acc;
    logic [4:0]  cnt;

    logic [1:0]  op;
    logic        accept;
    logic        a_sign, b_sign, b_sign_eff, a_zero, b_zero, a_inf, b_inf;
    logic [7:0]  ea, eb, big_e, small_e, exp_diff;
    logic [23:0] ma, mb, big_m, small_m;
    logic        swap, big_sign, small_sign;
    logic [25:0] small_al;
    logic [26:0] sum;
    logic [4:0]  lz;
    logic [33:0] add_packed, alu_packed, mul_packed;

    // Packed form is {overflow, underflow, fp32 word}.
    function automatic logic [33:0] pack_result(input logic sign, input logic [9:0] exp_biased,
                                                input logic [22:0] frac);
        if ($signed(exp_biased) >= 10'sd255)
            return {2'b10, sign, 8'hFF, 23'd0};
        else if ($signed(exp_biased) <= 10'sd0)
            return {2'b01, sign, 31'd0};
        else
            return {2'b00, sign, exp_biased[7:0], frac};
    endfunction

    assign op     = bus.FlagsIn[1:0];
    assign accept = (state == IDLE) && bus.FlagsIn[3];
    assign a_sign = bus.RLeftIn[31];
    assign b_sign = bus.RRightIn[31];
    assign ea     = bus.RLeftIn[30:23];
    assign eb     = bus.RRightIn[30:23];
    assign a_zero = (ea == 8'h00);
    assign b_zero = (eb == 8'h00);
    assign a_inf  = (ea == 8'hFF);
    assign b_inf  = (eb == 8'hFF);
    assign ma     = a_zero ? 24'd0 : {1'b1, bus.RLeftIn[22:0]};
    assign mb     = b_zero ? 24'd0 : {1'b1, bus.RRightIn[22:0]};

    always_comb begin
        b_sign_eff = b_sign ^ (op == OP_FSUB);
        swap       = {eb, mb} > {ea, ma};
        big_sign   = swap ? b_sign_eff : a_sign;
        small_sign = swap ? a_sign : b_sign_eff;
        big_e      = swap ? eb : ea;
        small_e    = swap ? ea : eb;
        big_m      = swap ? mb : ma;
        small_m    = swap ? ma : mb;
        exp_diff   = big_e - small_e;
        // Two guard bits below the mantissa; alignment past them leaves nothing.
        small_al   = (exp_diff >= 8'd26) ? 26'd0 : ({small_m, 2'b00} >> exp_diff);
        sum        = (big_sign != small_sign) ? ({1'b0, big_m, 2'b00} - {1'b0, small_al})
                                              : ({1'b0, big_m, 2'b00} + {1'b0, small_al});
        lz = 5'd0;
        for (int i = 0; i < 26; i++)
            if (sum[i]) lz = 5'(25 - i);
        if (a_inf && b_inf)
            add_packed = (a_sign != b_sign_eff) ? {2'b00, QNAN} : {2'b00, a_sign, 8'hFF, 23'd0};
        else if (a_inf)
            add_packed = {2'b00, a_sign, 8'hFF, 23'd0};
        else if (b_inf)
            add_packed = {2'b00, b_sign_eff, 8'hFF, 23'd0};
        else if (sum == 27'd0)
            add_packed = 34'd0;
        else if (sum[26])
            add_packed = pack_result(big_sign, {2'b00, big_e} + 10'd1, 23'(sum >> 3));
        else
            add_packed = pack_result(big_sign, {2'b00, big_e} - {5'd0, lz},
                                     23'((sum[25:0] << lz) >> 2));
        alu_packed = (op == OP_MOVE) ? {2'b00, bus.RLeftIn} : add_packed;
    end

    always_comb begin
        mul_packed = {2'b00, mul_special_res};
        if (!mul_special)
            mul_packed = acc[47] ? pack_result(mul_sign, mul_exp + 10'd1, 23'(acc >> 24))
                                 : pack_result(mul_sign, mul_exp, 23'(acc >> 23));
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept && op == OP_FMUL) state_next = MUL;
            MUL:  if (cnt == 5'd23) state_next = NORM;
            NORM: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q <= '0; rd_q <= '0; we_q <= 1'b0;
            done_q <= 1'b0; of_q <= 1'b0; uf_q <= 1'b0;
            mul_sign <= 1'b0; mul_exp <= '0; mcand <= '0; mplier <= '0;
            acc <= '0; cnt <= '0; mul_special <= 1'b0; mul_special_res <= '0;
            mul_rd <= '0; mul_we <= 1'b0;
        end else begin
            done_q <= 1'b0;
            of_q   <= 1'b0;
            uf_q   <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    if (op == OP_FMUL) begin
                        mul_sign    <= a_sign ^ b_sign;
                        mul_exp     <= {2'b00, ea} + {2'b00, eb} - 10'd127;
                        mcand       <= ma;
                        mplier      <= mb;
                        acc         <= '0;
                        cnt         <= '0;
                        mul_rd      <= bus.RDAddressIn;
                        mul_we      <= bus.FlagsIn[2];
                        mul_special <= a_inf || b_inf || a_zero || b_zero;
                        if ((a_inf && b_zero) || (b_inf && a_zero))
                            mul_special_res <= QNAN;
                        else if (a_inf || b_inf)
                            mul_special_res <= {a_sign ^ b_sign, 8'hFF, 23'd0};
                        else
                            mul_special_res <= {a_sign ^ b_sign, 31'd0};
                    end else begin
                        result_q <= alu_packed[31:0];
                        of_q     <= alu_packed[33];
                        uf_q     <= alu_packed[32];
                        rd_q     <= bus.RDAddressIn;
                        we_q     <= bus.FlagsIn[2];
                        done_q   <= 1'b1;
                    end
                end
                MUL: begin
                    if (mplier[cnt]) acc <= acc + ({24'd0, mcand} << cnt);
                    cnt <= cnt + 5'd1;
                end
                NORM: begin
                    result_q <= mul_packed[31:0];
                    of_q     <= mul_packed[33];
                    uf_q     <= mul_packed[32];
                    rd_q     <= mul_rd;
                    we_q     <= mul_we;
                    done_q   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.ResultOut    = result_q;
    assign bus.RDAddressOut = rd_q;
    assign bus.WriteEnOut   = we_q;
    assign bus.DoneOut      = done_q;
    assign bus.OverflowOut  = of_q;
    assign bus.UnderflowOut = uf_q;
    assign bus.Stall        = (state != IDLE);
endmodule

// File: tb/tb_fpu_execute_stage.sv
// tb/tb_fpu_execute_stage.sv - scoreboard bench for fpu_execute_stage
module tb_fpu_execute_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fpu_execute_stage_if bus();
    fpu_execute_stage dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        we;
        logic        of;
        logic        uf;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int failures = 0;

    // Every result pulse is matched against the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && bus.DoneOut === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_done: got result %h, required no DoneOut", bus.ResultOut);
                end else begin
                    e = sb.pop_front();
                    if ({bus.ResultOut, bus.RDAddressOut, bus.WriteEnOut, bus.OverflowOut, bus.UnderflowOut}
                        !== {e.res, e.rd, e.we, e.of, e.uf}) begin
                        failures++;
                        $display("FAIL result: got res=%h rd=%0d we=%b of=%b uf=%b, required res=%h rd=%0d we=%b of=%b uf=%b",
                                 bus.ResultOut, bus.RDAddressOut, bus.WriteEnOut, bus.OverflowOut, bus.UnderflowOut,
                                 e.res, e.rd, e.we, e.of, e.uf);
                    end
                end
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                         input logic [3:0] fl, input logic [31:0] r, input logic of, input logic uf);
        int n;
        @(negedge clk);
        bus.RLeftIn = a; bus.RRightIn = b; bus.RDAddressIn = rd; bus.FlagsIn = fl;
        sb.push_back('{r, rd, fl[2], of, uf});
        @(negedge clk);
        bus.FlagsIn = 4'b0000;
        n = 0;
        while (bus.Stall && n < 40) begin
            n++;
            @(negedge clk);
        end
        if (n >= 40) begin
            checks++; failures++;
            $display("FAIL timeout: Stall still high after %0d cycles, required low", n);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({bus.ResultOut, bus.RDAddressOut, bus.WriteEnOut, bus.DoneOut, bus.OverflowOut,
             bus.UnderflowOut, bus.Stall} !== 43'd0) begin
            failures++;
            $display("FAIL reset_outputs: got res=%h rd=%0d stall=%b done=%b, required all 0",
                     bus.ResultOut, bus.RDAddressOut, bus.Stall, bus.DoneOut);
        end
        rst = 1'b0;
    endtask

    task automatic test_fadd();
        @(negedge clk);
        bus.RLeftIn = 32'h3F80_0000; bus.RRightIn = 32'h4000_0000;
        bus.RDAddressIn = 5'd5; bus.FlagsIn = 4'b1100;
        sb.push_back('{32'h4040_0000, 5'd5, 1'b1, 1'b0, 1'b0});
        @(negedge clk);
        bus.FlagsIn = 4'b0000;
        checks++;
        if (bus.Stall !== 1'b0 || bus.DoneOut !== 1'b1) begin
            failures++;
            $display("FAIL fadd_timing: got stall=%b done=%b, required stall=0 done=1", bus.Stall, bus.DoneOut);
        end
        @(negedge clk);
        checks++;
        if (bus.DoneOut !== 1'b0) begin
            failures++;
            $display("FAIL fadd_done_pulse: got done=%b, required 0", bus.DoneOut);
        end
        issue(32'h40A0_0000, 32'h4040_0000, 5'd8, 4'b1101, 32'h4000_0000, 1'b0, 1'b0);
        issue(32'h3F80_0000, 32'h3080_0000, 5'd9, 4'b1100, 32'h3F80_0000, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        bus.RLeftIn = 32'h3F80_0000; bus.RRightIn = 32'h3F80_0000;
        bus.RDAddressIn = 5'd3; bus.FlagsIn = 4'b1101;
        sb.push_back('{32'h0000_0000, 5'd3, 1'b1, 1'b0, 1'b0});
        @(negedge clk);
        bus.RLeftIn = 32'hC228_0000; bus.RRightIn = 32'h1234_5678;
        bus.RDAddressIn = 5'd9; bus.FlagsIn = 4'b1011;
        sb.push_back('{32'hC228_0000, 5'd9, 1'b0, 1'b0, 1'b0});
        checks++;
        if (bus.DoneOut !== 1'b1) begin
            failures++;
            $display("FAIL b2b_first_done: got %b, required 1", bus.DoneOut);
        end
        @(negedge clk);
        bus.FlagsIn = 4'b0000;
        checks++;
        if (bus.DoneOut !== 1'b1) begin
            failures++;
            $display("FAIL b2b_second_done: got %b, required 1", bus.DoneOut);
        end
        @(negedge clk);
    endtask

    task automatic test_fmul_stall();
        int n;
        @(negedge clk);
        bus.RLeftIn = 32'h3FC0_0000; bus.RRightIn = 32'h4020_0000;
        bus.RDAddressIn = 5'd2; bus.FlagsIn = 4'b1110;
        sb.push_back('{32'h4070_0000, 5'd2, 1'b1, 1'b0, 1'b0});
        n = 0;
        @(negedge clk);
        while (bus.Stall && n < 40) begin
            n++;
            if (n == 3) begin
                bus.RLeftIn = 32'h4000_0000; bus.RRightIn = 32'h4000_0000;
                bus.RDAddressIn = 5'd7; bus.FlagsIn = 4'b1100;
                sb.push_back('{32'h4080_0000, 5'd7, 1'b1, 1'b0, 1'b0});
            end
            @(negedge clk);
        end
        checks++;
        if (n != 25) begin
            failures++;
            $display("FAIL fmul_stall_cycles: got %0d, required 25", n);
        end
        @(negedge clk);
        bus.FlagsIn = 4'b0000;
        checks++;
        if (bus.Stall !== 1'b0) begin
            failures++;
            $display("FAIL held_fadd_stall: got %b, required 0", bus.Stall);
        end
    endtask

    task automatic test_exceptions();
        issue(32'h7F00_0000, 32'h7F00_0000, 5'd1, 4'b1110, 32'h7F80_0000, 1'b1, 1'b0);
        issue(32'h0080_0000, 32'h0080_0000, 5'd4, 4'b1110, 32'h0000_0000, 1'b0, 1'b1);
        issue(32'h7F80_0000, 32'hFF80_0000, 5'd6, 4'b1100, 32'h7FC0_0000, 1'b0, 1'b0);
        issue(32'hBFC0_0000, 32'h4000_0000, 5'd10, 4'b1110, 32'hC040_0000, 1'b0, 1'b0);
        issue(32'h8000_0000, 32'h4000_0000, 5'd11, 4'b1110, 32'h8000_0000, 1'b0, 1'b0);
        issue(32'h7F80_0000, 32'h0000_0000, 5'd12, 4'b1110, 32'h7FC0_0000, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_mul();
        @(negedge clk);
        bus.RLeftIn = 32'h3FC0_0000; bus.RRightIn = 32'h4020_0000;
        bus.RDAddressIn = 5'd13; bus.FlagsIn = 4'b1110;
        repeat (10) @(negedge clk);
        checks++;
        if (bus.Stall !== 1'b1) begin
            failures++;
            $display("FAIL mid_mul_stall: got %b, required 1", bus.Stall);
        end
        rst = 1'b1;
        bus.FlagsIn = 4'b0000;
        #1;
        checks++;
        if ({bus.ResultOut, bus.RDAddressOut, bus.WriteEnOut, bus.DoneOut, bus.OverflowOut,
             bus.UnderflowOut, bus.Stall} !== 43'd0) begin
            failures++;
            $display("FAIL reset_mid_mul: got res=%h stall=%b done=%b, required all 0",
                     bus.ResultOut, bus.Stall, bus.DoneOut);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        issue(32'h3F80_0000, 32'h4000_0000, 5'd5, 4'b1100, 32'h4040_0000, 1'b0, 1'b0);
    endtask

    task automatic test_idle_hold();
        @(negedge clk);
        bus.RLeftIn = 32'h4120_0000; bus.RRightIn = 32'h4120_0000;
        bus.RDAddressIn = 5'd17; bus.FlagsIn = 4'b0110;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (bus.DoneOut !== 1'b0 || bus.ResultOut !== 32'h4040_0000 || bus.RDAddressOut !== 5'd5) begin
                failures++;
                $display("FAIL idle_hold: got done=%b res=%h rd=%0d, required done=0 res=40400000 rd=5",
                         bus.DoneOut, bus.ResultOut, bus.RDAddressOut);
            end
        end
        bus.FlagsIn = 4'b0000;
    endtask

    initial begin
        bus.RLeftIn = '0; bus.RRightIn = '0; bus.RDAddressIn = '0; bus.FlagsIn = '0;
        test_reset();
        test_fadd();
        test_back_to_back();
        test_fmul_stall();
        test_exceptions();
        test_reset_mid_mul();
        test_idle_hold();
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d outstanding, required 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
